// File: rtl/vdc_pkg.sv
// Shared types for the VDC video-RAM slot arbiter: slot owner encoding,
// address widths and the 16K/64K address fold.
package vdc_pkg;

  localparam int VDC_ADDR_W    = 16;
  localparam int VDC_ADDR16K_W = 14;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU,
    OWN_RFSH
  } owner_e;

  // With 64K addressing off, the top two address bits are forced low so 16K parts alias.
  function automatic logic [VDC_ADDR_W-1:0] fold_addr(input logic [VDC_ADDR_W-1:0] addr,
                                                       input logic full_64k);
    return full_64k ? addr
                    : {{(VDC_ADDR_W-VDC_ADDR16K_W){1'b0}}, addr[VDC_ADDR16K_W-1:0]};
  endfunction

endpackage

// File: rtl/vdc_refresh_ctr.sv
// DRAM refresh bookkeeping: pending-refresh counter, urgency flag and row counter.
// Present only in builds with VDC_ARB_REFRESH_EN defined.
module vdc_refresh_ctr
  import vdc_pkg::*;
#(
  parameter int RFSH_MAX = 31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_start,
  input  logic [3:0] reg_drr,
  input  logic       rfsh_slot,
  output logic [4:0] pending,
  output logic       urgent,
  output logic [7:0] row
);

  logic [4:0] pending_q, pending_d;
  logic       urgent_q, urgent_d;
  logic [7:0] row_q, row_d;
  logic [5:0] sum;

  // A refresh slot is only ever awarded while pending is non-zero, so the subtraction cannot underflow.
  always_comb begin
    sum       = {1'b0, pending_q} + {2'b00, reg_drr} - {5'd0, rfsh_slot};
    pending_d = pending_q;
    urgent_d  = urgent_q;
    row_d     = row_q;
    if (rfsh_slot) begin
      row_d = row_q + 8'd1;
    end
    if (line_start) begin
      pending_d = (sum > 6'(RFSH_MAX)) ? 5'(RFSH_MAX) : sum[4:0];
      if (pending_q != '0) begin
        urgent_d = 1'b1;
      end
    end else if (rfsh_slot) begin
      pending_d = pending_q - 5'd1;
    end
    if (pending_d == '0) begin
      urgent_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      urgent_q  <= 1'b0;
      row_q     <= '0;
    end else begin
      pending_q <= pending_d;
      urgent_q  <= urgent_d;
      row_q     <= row_d;
    end
  end

  assign pending = pending_q;
  assign urgent  = urgent_q;
  assign row     = row_q;

endmodule

// File: rtl/vdc_ram_slot_arbiter.sv
// Awards each enable-strobed VDC RAM slot to video, refresh or CPU and returns read data by owner tag.
// Build option: VDC_ARB_REFRESH_EN includes the DRAM refresh engine; without it slots go to video/CPU only.
module vdc_ram_slot_arbiter
  import vdc_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int RFSH_MAX = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        line_start,
  input  logic        ram64k,
  input  logic        reg_ram,
  input  logic [3:0]  reg_drr,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_gnt,
  output logic        vid_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic        ram_en,
  output logic        ram_we,
  output logic        ram_rfsh,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  rd_data,
  output logic [4:0]  rfsh_pending
);

  logic [4:0] pending;
  logic       urgent;
  logic [7:0] row;
  owner_e     sel;

`ifdef VDC_ARB_REFRESH_EN
  logic rfsh_slot;

  assign rfsh_slot = enable && (sel == OWN_RFSH);

  vdc_refresh_ctr #(
    .RFSH_MAX (RFSH_MAX)
  ) u_refresh_ctr (
    .clk        (clk),
    .reset_n    (reset_n),
    .line_start (line_start),
    .reg_drr    (reg_drr),
    .rfsh_slot  (rfsh_slot),
    .pending    (pending),
    .urgent     (urgent),
    .row        (row)
  );
`else
  logic unused_refresh_inputs;

  assign unused_refresh_inputs = ^{line_start, reg_drr};
  assign pending = '0;
  assign urgent  = 1'b0;
  assign row     = '0;
`endif

  logic        full_64k;
  owner_e      tag_in;
  owner_e      tag_q [RD_LAT+1];
  owner_e      tag_d [RD_LAT+1];

  logic        vid_gnt_q, vid_gnt_d;
  logic        cpu_gnt_q, cpu_gnt_d;
  logic        vid_rvalid_q, vid_rvalid_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        ram_en_q, ram_en_d;
  logic        ram_we_q, ram_we_d;
  logic        ram_rfsh_q, ram_rfsh_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_wdata_q, ram_wdata_d;
  logic [7:0]  rd_data_q, rd_data_d;

  assign full_64k = ram64k & reg_ram;

  // Urgent refresh outranks the CPU; background refresh only soaks up otherwise idle slots.
  always_comb begin
    sel = OWN_NONE;
    if (vid_req) begin
      sel = OWN_VID;
    end else if (urgent) begin
      sel = OWN_RFSH;
    end else if (cpu_req) begin
      sel = OWN_CPU;
    end else if (pending != '0) begin
      sel = OWN_RFSH;
    end
  end

  always_comb begin
    vid_gnt_d   = 1'b0;
    cpu_gnt_d   = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_rfsh_d  = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    tag_in      = OWN_NONE;
    if (enable) begin
      case (sel)
        OWN_VID: begin
          vid_gnt_d  = 1'b1;
          ram_en_d   = 1'b1;
          ram_addr_d = fold_addr(vid_addr, full_64k);
          tag_in     = OWN_VID;
        end
        OWN_CPU: begin
          cpu_gnt_d   = 1'b1;
          ram_en_d    = 1'b1;
          ram_we_d    = cpu_we;
          ram_addr_d  = fold_addr(cpu_addr, full_64k);
          ram_wdata_d = cpu_we ? cpu_wdata : 8'h00;
          tag_in      = cpu_we ? OWN_NONE : OWN_CPU;
        end
        OWN_RFSH: begin
          ram_en_d   = 1'b1;
          ram_rfsh_d = 1'b1;
          ram_addr_d = {8'h00, row};
        end
        default: begin
          tag_in = OWN_NONE;
        end
      endcase
    end
  end

  // The tag reaching the last stage marks the cycle in which ram_rdata belongs to that owner.
  always_comb begin
    tag_d[0] = tag_in;
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    vid_rvalid_d = (tag_q[RD_LAT] == OWN_VID);
    cpu_rvalid_d = (tag_q[RD_LAT] == OWN_CPU);
    rd_data_d    = rd_data_q;
    if (vid_rvalid_d || cpu_rvalid_d) begin
      rd_data_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_gnt_q    <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_rfsh_q   <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_data_q    <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= OWN_NONE;
      end
    end else begin
      vid_gnt_q    <= vid_gnt_d;
      cpu_gnt_q    <= cpu_gnt_d;
      vid_rvalid_q <= vid_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_rfsh_q   <= ram_rfsh_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_data_q    <= rd_data_d;
      for (int i = 0; i <= RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign vid_gnt      = vid_gnt_q;
  assign cpu_gnt      = cpu_gnt_q;
  assign vid_rvalid   = vid_rvalid_q;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_rfsh     = ram_rfsh_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign rd_data      = rd_data_q;
  assign rfsh_pending = pending;

endmodule
